// File: rtl/pcie_tx_arb_if.sv
// TRN transmit bundle shared by the TX requesters, the arbiter and the core.
// The slave modport is the arbiter's view; master is the surrounding fabric.
interface pcie_tx_arb_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]      req_v;
    logic [NUM_REQ-1:0]      req_done;
    logic [NUM_REQ-1:0]      req_grant;
    logic                    req_stall;
    logic [64*NUM_REQ-1:0]   req_td;
    logic [8*NUM_REQ-1:0]    req_trem_n;
    logic [NUM_REQ-1:0]      req_tsof_n;
    logic [NUM_REQ-1:0]      req_teof_n;
    logic [NUM_REQ-1:0]      req_tsrc_rdy_n;
    logic [63:0]             trn_td;
    logic [7:0]              trn_trem_n;
    logic                    trn_tsof_n;
    logic                    trn_teof_n;
    logic                    trn_tsrc_rdy_n;
    logic                    trn_tdst_rdy_n;
    logic [5:0]              trn_tbuf_av;
    logic                    proto_err;
    logic                    timeout_err;

    modport slave (
        input  req_v, req_done, req_td, req_trem_n,
        input  req_tsof_n, req_teof_n, req_tsrc_rdy_n,
        input  trn_tdst_rdy_n, trn_tbuf_av,
        output req_grant, req_stall,
        output trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
        output proto_err, timeout_err
    );

    modport master (
        output req_v, req_done, req_td, req_trem_n,
        output req_tsof_n, req_teof_n, req_tsrc_rdy_n,
        output trn_tdst_rdy_n, trn_tbuf_av,
        input  req_grant, req_stall,
        input  trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
        input  proto_err, timeout_err
    );
endinterface

// File: rtl/pcie_tx_arb.sv
// Round-robin packet arbiter and TRN mux in front of the PCIe TX core,
// with buffer gating, grant watchdog and sticky protocol error flags.
module pcie_tx_arb #(
    parameter int NUM_REQ  = 3,
    parameter int BUF_MIN  = 1,
    parameter int TIMEOUT  = 1024,
    parameter int CNT_BITS = 16
) (
    input  logic         pcie_clk,
    input  logic         rst,
    pcie_tx_arb_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [CNT_BITS-1:0] WD_LAST = CNT_BITS'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        GRANTED
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_BITS-1:0] wd_cnt_q, wd_cnt_d;
    logic                proto_err_q, proto_err_d;
    logic                timeout_err_q, timeout_err_d;

    logic                found;
    logic [IW-1:0]       win_idx;
    logic [IW-1:0]       gnt_idx;
    logic [IW-1:0]       next_ptr;
    logic                eligible;
    logic                done_hit;
    logic                done_stray;
    logic                wd_fire;

    // First pending requester at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx     = 0;
        found   = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && bus.req_v[idx]) begin
                found   = 1'b1;
                win_idx = IW'(idx);
            end
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                gnt_idx = IW'(i);
            end
        end
    end

    assign next_ptr   = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign eligible   = found && (int'(bus.trn_tbuf_av) >= BUF_MIN);
    assign done_hit   = (state_q == GRANTED) && |(bus.req_done & grant_q);
    assign done_stray = |(bus.req_done & ~grant_q);
    assign wd_fire    = (state_q == GRANTED) && !done_hit
                        && (wd_cnt_q == WD_LAST);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        wd_cnt_d      = wd_cnt_q;
        proto_err_d   = proto_err_q | done_stray;
        timeout_err_d = timeout_err_q | wd_fire;
        unique case (state_q)
            IDLE: begin
                if (eligible) begin
                    state_d  = GRANTED;
                    grant_d  = NUM_REQ'(1) << win_idx;
                    wd_cnt_d = '0;
                end
            end
            GRANTED: begin
                wd_cnt_d = wd_cnt_q + 1'b1;
                if (done_hit || wd_fire) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge pcie_clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            wd_cnt_q      <= '0;
            proto_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            wd_cnt_q      <= wd_cnt_d;
            proto_err_q   <= proto_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // AND-OR mux; active-low lines are inverted so zero grant yields idle.
    logic [63:0] td_mux;
    logic [7:0]  rem_act;
    logic        sof_act;
    logic        eof_act;
    logic        src_act;

    always_comb begin
        td_mux  = '0;
        rem_act = '0;
        sof_act = 1'b0;
        eof_act = 1'b0;
        src_act = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            td_mux  = td_mux
                      | (bus.req_td[64*i +: 64] & {64{grant_q[i]}});
            rem_act = rem_act
                      | (~bus.req_trem_n[8*i +: 8] & {8{grant_q[i]}});
            sof_act = sof_act | (~bus.req_tsof_n[i] & grant_q[i]);
            eof_act = eof_act | (~bus.req_teof_n[i] & grant_q[i]);
            src_act = src_act | (~bus.req_tsrc_rdy_n[i] & grant_q[i]);
        end
    end

    assign bus.trn_td         = td_mux;
    assign bus.trn_trem_n     = ~rem_act;
    assign bus.trn_tsof_n     = ~sof_act;
    assign bus.trn_teof_n     = ~eof_act;
    assign bus.trn_tsrc_rdy_n = ~src_act;
    assign bus.req_stall      = bus.trn_tdst_rdy_n;
    assign bus.req_grant      = grant_q;
    assign bus.proto_err      = proto_err_q;
    assign bus.timeout_err    = timeout_err_q;
endmodule

// File: tb/tb_pcie_tx_arb.sv
// Bench for pcie_tx_arb: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a packet-level model.
module tb_pcie_tx_arb;
    localparam int N   = 3;
    localparam int BMN = 1;
    localparam int TO  = 16;

    logic pcie_clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pcie_tx_arb_if #(.NUM_REQ(N)) bus ();

    pcie_tx_arb #(
        .NUM_REQ (N),
        .BUF_MIN (BMN),
        .TIMEOUT (TO),
        .CNT_BITS(16)
    ) dut (
        .pcie_clk(pcie_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 pcie_clk = ~pcie_clk;

    // Packet-level model: who owns the core, how long, whose turn is next.
    int m_owner = -1;
    int m_rr    = 0;
    int m_age   = 0;
    bit m_perr  = 1'b0;
    bit m_terr  = 1'b0;

    always @(posedge pcie_clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_rr    = 0;
            m_age   = 0;
            m_perr  = 1'b0;
            m_terr  = 1'b0;
        end else begin
            for (int i = 0; i < N; i++)
                if (bus.req_done[i] && i != m_owner) m_perr = 1'b1;
            if (m_owner < 0) begin
                if (bus.req_v != 0 && int'(bus.trn_tbuf_av) >= BMN) begin
                    for (int k = N - 1; k >= 0; k--)
                        if (bus.req_v[(m_rr + k) % N]) m_owner = (m_rr + k) % N;
                    m_age = 0;
                end
            end else if (bus.req_done[m_owner]) begin
                m_rr    = (m_owner + 1) % N;
                m_owner = -1;
            end else if (m_age == TO - 1) begin
                m_terr  = 1'b1;
                m_rr    = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_age++;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_cmp();
        logic [N-1:0] e_g;
        logic [63:0]  e_td;
        logic [7:0]   e_rem;
        logic         e_sof, e_eof, e_src;
        e_g   = '0;
        e_td  = '0;
        e_rem = 8'hFF;
        e_sof = 1'b1;
        e_eof = 1'b1;
        e_src = 1'b1;
        if (m_owner >= 0) begin
            e_g[m_owner] = 1'b1;
            e_td  = bus.req_td[64*m_owner +: 64];
            e_rem = bus.req_trem_n[8*m_owner +: 8];
            e_sof = bus.req_tsof_n[m_owner];
            e_eof = bus.req_teof_n[m_owner];
            e_src = bus.req_tsrc_rdy_n[m_owner];
        end
        chk("m_grant", bus.req_grant, e_g);
        chk("m_stall", bus.req_stall, bus.trn_tdst_rdy_n);
        chk("m_td", bus.trn_td, e_td);
        chk("m_trem", bus.trn_trem_n, e_rem);
        chk("m_sof", bus.trn_tsof_n, e_sof);
        chk("m_eof", bus.trn_teof_n, e_eof);
        chk("m_src", bus.trn_tsrc_rdy_n, e_src);
        chk("m_perr", bus.proto_err, m_perr);
        chk("m_terr", bus.timeout_err, m_terr);
    endtask

    task automatic tick();
        @(negedge pcie_clk);
        model_cmp();
        @(posedge pcie_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_v          = '0;
        bus.req_done       = '0;
        bus.req_td         = '0;
        bus.req_trem_n     = '1;
        bus.req_tsof_n     = '1;
        bus.req_teof_n     = '1;
        bus.req_tsrc_rdy_n = '1;
        bus.trn_tdst_rdy_n = 1'b0;
        bus.trn_tbuf_av    = 6'd8;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic rand_inputs(input int done_pct, input int stray_pct);
        for (int i = 0; i < 2 * N; i++) bus.req_td[32*i +: 32] = $urandom;
        bus.req_trem_n     = (8*N)'($urandom);
        bus.req_tsof_n     = N'($urandom);
        bus.req_teof_n     = N'($urandom);
        bus.req_tsrc_rdy_n = N'($urandom);
        bus.req_v          = N'($urandom);
        bus.trn_tdst_rdy_n = ($urandom_range(0, 3) == 0);
        bus.trn_tbuf_av    = 6'($urandom_range(0, 3));
        bus.req_done       = '0;
        if (m_owner >= 0 && int'($urandom_range(0, 99)) < done_pct)
            bus.req_done[m_owner] = 1'b1;
        if (int'($urandom_range(0, 99)) < stray_pct)
            bus.req_done[$urandom_range(0, N - 1)] = 1'b1;
    endtask

    logic [N-1:0] order [4];
    logic [63:0]  held;

    initial begin
        order[0] = 3'b001;
        order[1] = 3'b010;
        order[2] = 3'b100;
        order[3] = 3'b001;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_grant", bus.req_grant, 0);
        chk("rst_td", bus.trn_td, 0);
        chk("rst_trem", bus.trn_trem_n, 8'hFF);
        chk("rst_src", bus.trn_tsrc_rdy_n, 1);
        chk("rst_perr", bus.proto_err, 0);
        chk("rst_terr", bus.timeout_err, 0);

        // Single requester, two-beat packet.
        bus.req_v         = 3'b001;
        bus.req_td[63:0]  = 64'h1111_2222_3333_4444;
        tick();
        chk("a_grant", bus.req_grant, 3'b001);
        bus.req_tsof_n[0]     = 1'b0;
        bus.req_tsrc_rdy_n[0] = 1'b0;
        #1;
        chk("a_sof", bus.trn_tsof_n, 0);
        chk("a_td", bus.trn_td, 64'h1111_2222_3333_4444);
        tick();
        bus.req_tsof_n[0] = 1'b1;
        bus.req_teof_n[0] = 1'b0;
        bus.req_done      = 3'b001;
        bus.req_v         = 3'b000;
        #1;
        chk("a_eof", bus.trn_teof_n, 0);
        tick();
        chk("a_release", bus.req_grant, 0);
        idle_inputs();

        // All requesting: rotation with one idle cycle between grants.
        do_reset();
        bus.req_v = 3'b111;
        for (int p = 0; p < 4; p++) begin
            tick();
            chk("b_grant", bus.req_grant, order[p]);
            tick();
            bus.req_done = order[p];
            tick();
            chk("b_idle", bus.req_grant, 0);
            bus.req_done = '0;
        end
        bus.req_v = '0;

        // Core backpressure mid-packet.
        held              = 64'hDEAD_BEEF_0123_4567;
        bus.req_v         = 3'b010;
        bus.req_td[127:64] = held;
        tick();
        chk("c_grant", bus.req_grant, 3'b010);
        bus.trn_tdst_rdy_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("c_stall", bus.req_stall, 1);
            chk("c_td", bus.trn_td, held);
            chk("c_hold", bus.req_grant, 3'b010);
            tick();
        end
        bus.trn_tdst_rdy_n = 1'b0;
        #1;
        chk("c_unstall", bus.req_stall, 0);
        bus.req_done = 3'b010;
        bus.req_v    = '0;
        tick();
        chk("c_release", bus.req_grant, 0);
        bus.req_done = '0;

        // No buffers, no grant.
        bus.trn_tbuf_av = 6'd0;
        bus.req_v       = 3'b010;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("d_nobuf", bus.req_grant, 0);
        end
        bus.trn_tbuf_av = 6'd1;
        tick();
        chk("d_grant", bus.req_grant, 3'b010);
        bus.req_done = 3'b010;
        bus.req_v    = '0;
        tick();
        chk("d_release", bus.req_grant, 0);
        bus.req_done = '0;

        // Watchdog: requester 0 never completes.
        bus.req_v = 3'b011;
        tick();
        chk("e_grant", bus.req_grant, 3'b001);
        for (int i = 1; i < TO; i++) begin
            tick();
            chk("e_hold", bus.req_grant, 3'b001);
        end
        tick();
        chk("e_drop", bus.req_grant, 0);
        chk("e_terr", bus.timeout_err, 1);
        tick();
        chk("e_next", bus.req_grant, 3'b010);
        bus.req_done = 3'b010;
        bus.req_v    = '0;
        tick();
        chk("e_release", bus.req_grant, 0);
        bus.req_done = '0;

        // Stray done, then asynchronous reset mid-packet.
        bus.req_v = 3'b001;
        tick();
        chk("f_grant", bus.req_grant, 3'b001);
        bus.req_tsrc_rdy_n[0] = 1'b0;
        bus.req_done          = 3'b100;
        tick();
        bus.req_done = '0;
        chk("f_perr", bus.proto_err, 1);
        chk("f_keep", bus.req_grant, 3'b001);
        chk("f_src", bus.trn_tsrc_rdy_n, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("f_arst_grant", bus.req_grant, 0);
        chk("f_arst_src", bus.trn_tsrc_rdy_n, 1);
        chk("f_arst_perr", bus.proto_err, 0);
        chk("f_arst_terr", bus.timeout_err, 0);
        tick();
        rst = 1'b0;
        idle_inputs();

        // Randomized traffic against the model.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            repeat (600) begin
                case (r)
                    0:       rand_inputs(35, 3);
                    1:       rand_inputs(3, 0);
                    default: rand_inputs(60, 0);
                endcase
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pcie_tx_arb.md
Name: pcie_tx_arb

Overview:
- Round-robin arbiter and multiplexer for the shared PCIe TRN transmit interface.
- Requesters are the read-request, write and completion TX engines. Each speaks the v/grant/stall/done protocol and drives its own TRN lines.
- Grants the core to one requester per packet, broadcasts the core's backpressure as stall, and muxes the winner's TRN signals to the core.
- Gates grants on core buffer availability and watchdogs a granted requester that never completes.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- BUF_MIN, 1, minimum trn_tbuf_av required to issue a grant.
- TIMEOUT, 1024, maximum cycles a grant may be held before forced release.
- CNT_BITS, 16, width of the watchdog counter; must satisfy 2^CNT_BITS > TIMEOUT.

Ports:
- pcie_clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_v  in  NUM_REQ  per-requester request valid
- req_done  in  NUM_REQ  per-requester last-beat-accepted indication
- req_grant  out  NUM_REQ  one-hot grant, registered
- req_stall  out  1  shared stall, equal to trn_tdst_rdy_n
- req_td  in  64*NUM_REQ  requester data, requester i in [64*i+:64]
- req_trem_n  in  8*NUM_REQ  requester remainder
- req_tsof_n, req_teof_n, req_tsrc_rdy_n  in  NUM_REQ each  requester framing
- trn_td  out  64  to core
- trn_trem_n  out  8  to core
- trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n  out  1 each  to core
- trn_tdst_rdy_n  in  1  core ready, active low
- trn_tbuf_av  in  6  core free TX buffers
- proto_err  out  1  sticky: req_done asserted by a non-granted requester
- timeout_err  out  1  sticky: watchdog fired

Behaviour:
- Reset: asynchronous. req_grant=0, state=IDLE, rr_ptr=0, wd_cnt=0, proto_err=0, timeout_err=0.
- Reset takes effect immediately, including mid-packet. The TRN outputs go idle with no clock edge.
- Idle TRN values: trn_td=0, trn_trem_n=8'hFF, trn_tsof_n=1, trn_teof_n=1, trn_tsrc_rdy_n=1.
- TRN mux: combinational on req_grant. One-hot grant selects that requester's TRN bundle. Zero grant drives the idle TRN values.
- req_stall = trn_tdst_rdy_n, combinational, broadcast to all requesters regardless of grant.
- States: IDLE and GRANTED.
- IDLE:
  - Eligible when any req_v is high and trn_tbuf_av >= BUF_MIN.
  - Winner is the first set req_v bit searching from rr_ptr upward, wrapping at NUM_REQ-1 to 0.
  - At the next edge: req_grant = onehot(winner), state = GRANTED, wd_cnt = 0.
  - Latency: req_v high in cycle N gives grant in cycle N+1.
- GRANTED:
  - wd_cnt increments each cycle.
  - On req_done[g]=1 for granted index g: at the edge, req_grant=0, state=IDLE, rr_ptr=(g+1) mod NUM_REQ.
  - At least one IDLE cycle separates consecutive grants. The same requester may win again only if no other requester is pending.
- Grant hold:
  - req_v deasserting while granted does not revoke the grant. The grant is held until done or timeout.
  - trn_tbuf_av dropping below BUF_MIN while granted does not revoke the grant.
- Watchdog: if wd_cnt reaches TIMEOUT-1 in GRANTED without done, then at the edge timeout_err=1 (sticky), req_grant=0, state=IDLE and rr_ptr advances as for done. Handling of the truncated packet is the requester's responsibility.
- req_done from a non-granted index, or any req_done in IDLE: ignored, proto_err=1 (sticky).
- Simultaneous valid done and stray done: the valid done is honoured and proto_err is set.
- Only rst clears proto_err and timeout_err.
- req_grant is never multi-hot.

Test Plan:
- Single requester: req_v[0]=1 at cycle 0 → req_grant=3'b001 at cycle 1. Two-beat packet; done at cycle 2 → grant 0 at cycle 3. trn_tsof_n/teof_n mirror requester 0.
- All three requesters held requesting, each packet two beats → grant order 001, 010, 100, 001. Exactly one idle cycle between grants.
- trn_tdst_rdy_n=1 for 5 cycles mid-packet → req_stall=1 for those 5 cycles. Grant held; trn_td equals the requester's held value throughout.
- trn_tbuf_av=0 with req_v=3'b010 → no grant. trn_tbuf_av=1 at cycle 10 → req_grant=3'b010 at cycle 11.
- TIMEOUT=16, granted requester never asserts done → grant drops after 16 granted cycles, timeout_err=1, next pending requester granted.
- req_done[2] pulsed while requester 0 is granted → proto_err=1 and grant unchanged. Then rst mid-packet → trn_tsrc_rdy_n=1 and req_grant=0 before the next clock edge, both error flags cleared.
